// File: rtl/c17v2_bist.sv
// rtl/c17v2_bist.sv - registered C17V2 slice array with LFSR/MISR self-test
module c17v2_bist #(
    parameter int          NUM_CH     = 1,
    parameter int          N_PATTERNS = 32,
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  bist_start,
    input  logic [5*NUM_CH-1:0]   func_in,
    output logic [2*NUM_CH-1:0]   func_out,
    output logic                  bist_busy,
    output logic                  bist_done,
    output logic                  bist_pass,
    output logic [15:0]           signature
);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [15:0] LAST_CNT = 16'(N_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                start_ok;
    logic                flush_cnt;
    logic [31:0]         lfsr;
    logic [31:0]         lfsr_nx;
    logic [15:0]         misr;
    logic [15:0]         misr_nx;
    logic [15:0]         cnt;
    logic [5*NUM_CH-1:0] in_reg;
    logic [2*NUM_CH-1:0] out_reg;
    logic [2*NUM_CH-1:0] slice_out;
    logic                v1;
    logic                v2;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_slice
        logic g1, g2, g3, g4, g5;
        logic w1, w2, w3;
        assign {g5, g4, g3, g2, g1} = in_reg[5*c +: 5];
        assign w1 = ~(g5 & g1);
        assign w2 = ~(g5 & g2);
        assign w3 = ~(w2 & g4);
        assign slice_out[2*c]   = ~(w1 & w3);
        assign slice_out[2*c+1] = (g4 | g3) & w2;
    end

    assign lfsr_nx = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 32'h0);
    assign misr_nx = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0)
                   ^ {{(16-2*NUM_CH){1'b0}}, out_reg};

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bist_start) begin
                    state_nx = RUN;
                    start_ok = 1'b1;
                end
            end
            RUN:     if (cnt == LAST_CNT) state_nx = FLUSH;
            FLUSH:   if (flush_cnt) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
            lfsr      <= SEED_EFF;
            misr      <= 16'h0;
            cnt       <= 16'h0;
            in_reg    <= '0;
            out_reg   <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
        end else begin
            state     <= state_nx;
            flush_cnt <= (state == FLUSH) && !flush_cnt;
            v1        <= (state == RUN);
            v2        <= v1;
            out_reg   <= slice_out;
            // FLUSH keeps the last pattern applied while the pipeline drains.
            if (state == RUN)
                in_reg <= lfsr[5*NUM_CH-1:0];
            else if (state != FLUSH)
                in_reg <= func_in;
            if (start_ok) begin
                lfsr <= SEED_EFF;
                misr <= 16'h0;
                cnt  <= 16'h0;
            end else begin
                if (state == RUN) begin
                    lfsr <= lfsr_nx;
                    cnt  <= cnt + 16'd1;
                end
                if (v2)
                    misr <= misr_nx;
            end
        end
    end

    assign func_out  = out_reg;
    assign bist_busy = (state == RUN) || (state == FLUSH);
    assign bist_done = (state == DONE);
    assign bist_pass = (state == DONE) && (misr == GOLDEN_SIG);
    assign signature = misr;
endmodule

// File: tb/tb_c17v2_bist.sv
// tb/tb_c17v2_bist.sv - self-checking bench for c17v2_bist
module tb_c17v2_bist;
    localparam int          NP    = 32;
    localparam logic [15:0] GOLD6 = 16'h0000;

    logic        ck = 1'b0;
    logic        rst;
    logic        start1;
    logic        start6;
    logic [4:0]  fin1;
    logic [29:0] fin6;

    logic [1:0]  fout1, fout1b;
    logic        busy1, done1, pass1, busy1b, done1b, pass1b;
    logic [15:0] sig1, sig1b;
    logic [11:0] fout6, fout6z;
    logic        busy6, done6, pass6, busy6z, done6z, pass6z;
    logic [15:0] sig6, sig6z;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int k6    = -1;
    bit chk_en = 1'b0;

    logic [29:0] pat6     [1:NP];
    logic [15:0] psig6    [0:NP];
    logic [29:0] applied  [0:4095];
    bit          rst_edge [0:4095];

    c17v2_bist #(.NUM_CH(1), .N_PATTERNS(1), .SEED(32'h1), .GOLDEN_SIG(16'h0000)) u1 (
        .CK(ck), .RST(rst), .bist_start(start1), .func_in(fin1), .func_out(fout1),
        .bist_busy(busy1), .bist_done(done1), .bist_pass(pass1), .signature(sig1));
    c17v2_bist #(.NUM_CH(1), .N_PATTERNS(1), .SEED(32'h1), .GOLDEN_SIG(16'h0001)) u1b (
        .CK(ck), .RST(rst), .bist_start(start1), .func_in(fin1), .func_out(fout1b),
        .bist_busy(busy1b), .bist_done(done1b), .bist_pass(pass1b), .signature(sig1b));
    c17v2_bist #(.NUM_CH(6), .N_PATTERNS(NP), .SEED(32'h1), .GOLDEN_SIG(GOLD6)) u6 (
        .CK(ck), .RST(rst), .bist_start(start6), .func_in(fin6), .func_out(fout6),
        .bist_busy(busy6), .bist_done(done6), .bist_pass(pass6), .signature(sig6));
    c17v2_bist #(.NUM_CH(6), .N_PATTERNS(NP), .SEED(32'h0), .GOLDEN_SIG(GOLD6)) u6z (
        .CK(ck), .RST(rst), .bist_start(start6), .func_in(fin6), .func_out(fout6z),
        .bist_busy(busy6z), .bist_done(done6z), .bist_pass(pass6z), .signature(sig6z));

    always #5 ck = ~ck;

    function automatic logic [11:0] ix(input int e);
        return 12'(e);
    endfunction

    function automatic logic [1:0] c17(input logic [4:0] g);
        logic w1, w2, w3;
        w1 = ~(g[4] & g[0]);
        w2 = ~(g[4] & g[1]);
        w3 = ~(w2 & g[3]);
        return {(g[3] | g[2]) & w2, ~(w1 & w3)};
    endfunction

    function automatic logic [11:0] resp6(input logic [29:0] x);
        logic [11:0] r;
        r = '0;
        for (int c = 0; c < 6; c++) r[2*c +: 2] = c17(x[5*c +: 5]);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #2;
        end
    endtask

    task automatic wait_done6();
        int n;
        n = 0;
        while (!done6 && n < 200) begin
            tick(1);
            n++;
        end
        chk("u6_done_in_time", 32'(done6), 32'h1);
    endtask

    // Timeline model: what the slices see at each edge, relative to the last honoured start.
    always @(posedge ck) begin
        int d;
        rst_edge[ix(cyc)] = rst;
        if (rst) begin
            applied[ix(cyc)] = '0;
            k6 = -1;
        end else begin
            if (start6 && (k6 < 0 || cyc - k6 >= NP + 3)) k6 = cyc;
            d = cyc - k6;
            if (k6 >= 0 && d >= 1 && d <= NP)
                applied[ix(cyc)] = pat6[d];
            else if (k6 >= 0 && (d == NP + 1 || d == NP + 2))
                applied[ix(cyc)] = pat6[NP];
            else
                applied[ix(cyc)] = fin6;
        end
        cyc = cyc + 1;
    end

    always @(negedge ck) begin
        int e, d;
        logic [11:0] ef;
        logic [15:0] es;
        logic eb, ed, ep;
        if (chk_en) begin
            e  = cyc - 1;
            ef = '0;
            es = '0;
            eb = 1'b0;
            ed = 1'b0;
            ep = 1'b0;
            if (!rst && !rst_edge[ix(e)]) ef = resp6(applied[ix(e - 1)]);
            if (!rst && k6 >= 0) begin
                d  = e - k6;
                eb = (d <= NP + 1);
                ed = (d >= NP + 2);
                es = (d < 2) ? 16'h0 : (d > NP + 2) ? psig6[NP] : psig6[d - 2];
                ep = ed && (psig6[NP] == GOLD6);
            end
            chk("u6_func_out", 32'(fout6), 32'(ef));
            chk("u6_busy", 32'(busy6), 32'(eb));
            chk("u6_done", 32'(done6), 32'(ed));
            chk("u6_pass", 32'(pass6), 32'(ep));
            chk("u6_signature", 32'(sig6), 32'(es));
        end
    end

    initial begin
        logic [31:0] l;
        rst = 1'b1; start1 = 1'b0; start6 = 1'b0; fin1 = '0; fin6 = '0;

        l = 32'h1;
        psig6[0] = 16'h0;
        for (int j = 1; j <= NP; j++) begin
            pat6[j]  = l[29:0];
            l        = {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0);
            psig6[j] = {psig6[j-1][14:0], 1'b0} ^ (psig6[j-1][15] ? 16'h1021 : 16'h0)
                     ^ {4'h0, resp6(pat6[j])};
        end
        chk("model_pat1", 32'(pat6[1]), 32'h1);
        chk("model_pat32", 32'(pat6[32]), 32'h0);
        chk("model_resp_g3", 32'(resp6(pat6[3])), 32'h002);
        chk("model_resp_g4", 32'(resp6(pat6[4])), 32'h003);

        tick(2);
        chk("rst_fout1", 32'(fout1), 32'h0);
        chk("rst_fout6", 32'(fout6), 32'h0);
        chk("rst_sig6", 32'(sig6), 32'h0);
        chk("rst_busy6", 32'(busy6), 32'h0);
        chk("rst_done6", 32'(done6), 32'h0);
        chk("rst_pass1", 32'(pass1), 32'h0);
        rst = 1'b0;
        tick(1);
        chk_en = 1'b1;

        fin1 = 5'b11111; tick(1);
        fin1 = 5'b00000; tick(1);
        chk("f1_11111", 32'(fout1), 32'h1);
        fin1 = 5'b00100; tick(1);
        chk("f1_00000", 32'(fout1), 32'h0);
        tick(1);
        chk("f1_00100", 32'(fout1), 32'h2);
        chk("f1b_00100", 32'(fout1b), 32'h2);

        fin6 = {5'b10001, 5'b01000, 5'b00001, 5'b00100, 5'b00000, 5'b11111};
        tick(2);
        chk("f6_lanes", 32'(fout6), 32'h721);
        for (int i = 0; i < 8; i++) begin
            fin6 = 30'($urandom);
            tick(1);
        end

        start1 = 1'b1; tick(1); start1 = 1'b0;
        chk("b1_busy_k", 32'(busy1), 32'h1);
        tick(1);
        chk("b1_out_k1", 32'(fout1), 32'h2);
        tick(1);
        chk("b1_pattern_resp", 32'(fout1), 32'h0);
        chk("b1_not_done_k2", 32'(done1), 32'h0);
        tick(1);
        chk("b1_done_k3", 32'(done1), 32'h1);
        chk("b1_busy_k3", 32'(busy1), 32'h0);
        chk("b1_sig", 32'(sig1), 32'h0);
        chk("b1_pass", 32'(pass1), 32'h1);
        chk("b1b_done", 32'(done1b), 32'h1);
        chk("b1b_pass", 32'(pass1b), 32'h0);

        start6 = 1'b1; tick(1); start6 = 1'b0;
        tick(5);
        start6 = 1'b1; tick(1); start6 = 1'b0;
        wait_done6();
        chk("b6_sig", 32'(sig6), 32'(psig6[NP]));
        chk("b6z_done", 32'(done6z), 32'h1);
        chk("b6z_sig", 32'(sig6z), 32'(psig6[NP]));

        tick(3);
        start6 = 1'b1; tick(1); start6 = 1'b0;
        wait_done6();
        chk("b6_restart_sig", 32'(sig6), 32'(psig6[NP]));

        tick(2);
        start6 = 1'b1; tick(1); start6 = 1'b0;
        tick(10);
        chk("b6_busy_before_rst", 32'(busy6), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy6), 32'h0);
        chk("async_rst_sig", 32'(sig6), 32'h0);
        chk("async_rst_fout", 32'(fout6), 32'h0);
        chk("async_rst_done", 32'(done6), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(2);
        start6 = 1'b1; tick(1); start6 = 1'b0;
        wait_done6();
        chk("b6_after_rst_sig", 32'(sig6), 32'(psig6[NP]));

        tick(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/c17v2_bist.md
# c17v2_bist

Parametrised, registered array of NUM_CH C17V2 benchmark slices with a built-in self-test (BIST) wrapper. It is the sequential successor to the combinational C17V2 netlist. It sits in the fault-tolerance benchmark set as a device-under-test for fault-injection campaigns:
- functional mode: registered pass-through of the C17V2 function;
- BIST mode: an on-chip LFSR drives the slices, a MISR compacts their responses, and the result is compared against a golden signature.

## Interface
- NUM_CH, 1: number of C17V2 slices; legal range 1..6.
- N_PATTERNS, 32: patterns applied per BIST run; legal range 1..65535.
- SEED, 32'h0000_0001: LFSR load value at reset and at each BIST start. A value of 0 is replaced by 1.
- GOLDEN_SIG, 16'h0000: expected MISR signature.
- CK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- bist_start  in  1  single-cycle start request; honoured only in IDLE or DONE.
- func_in  in  5*NUM_CH  functional stimulus. Channel c uses bits [5c+4:5c], ordered G1..G5 (G1 = bit 5c).
- func_out  out  2*NUM_CH  registered responses: bit 2c = G6 of channel c, bit 2c+1 = G7 of channel c.
- bist_busy  out  1  high in RUN and FLUSH.
- bist_done  out  1  high in DONE.
- bist_pass  out  1  in DONE: (signature == GOLDEN_SIG); 0 in every other state.
- signature  out  16  current MISR contents.

## Operation
- Slice function, per channel:
  - w1 = ~(G5&G1), w2 = ~(G5&G2), w3 = ~(w2&G4)
  - G6 = ~(w1&w3), G7 = (G4|G3)&w2
- Datapath:
  - in_reg (5*NUM_CH bits) feeds the slices combinationally;
  - out_reg (2*NUM_CH bits) captures the slice outputs;
  - func_out = out_reg.
- in_reg source:
  - func_in in IDLE/DONE;
  - lfsr[5*NUM_CH-1:0] in RUN;
  - held in FLUSH.
- LFSR (32 bit, Galois): next = {lfsr[30:0],1'b0} ^ (lfsr[31] ? 32'h0040_0007 : 0). It advances only on RUN cycles.
- MISR (16 bit): next = {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ zero-extend(out_reg). It updates only when valid bit v2 = 1.
- Valid pipeline:
  - v1 <= (state == RUN);
  - v2 <= v1.
- Pattern counter: 16 bit, cleared on start, incremented on each RUN cycle.
- FSM:
  - IDLE: bist_start → RUN. On that edge: lfsr <= SEED, misr <= 0, counter <= 0.
  - RUN: after the N_PATTERNS-th capture → FLUSH.
  - FLUSH: 2 cycles → DONE.
  - DONE: holds signature and bist_pass. bist_start → RUN (same reload as from IDLE).
- bist_start in RUN or FLUSH is ignored.
- Functional inputs are ignored during RUN and FLUSH. func_out then shows BIST responses.

## Timing
- Reset (asynchronous) values:
  - state = IDLE; lfsr = SEED (or 1 if SEED = 0); misr = 0; counter = 0;
  - in_reg = 0, out_reg = 0, v1 = v2 = 0;
  - func_out = 0, bist_busy = 0, bist_done = 0, bist_pass = 0, signature = 0.
- Functional latency: func_in sampled at edge t appears on func_out after edge t+1 (2-register pipeline, throughput 1 per cycle).
- BIST sequence, with bist_start sampled at edge k:
  - RUN from k;
  - patterns captured at edges k+1..k+N;
  - out_reg valid at k+2..k+N+1;
  - MISR compactions at k+3..k+N+2;
  - DONE entered at edge k+N+2; bist_done and bist_pass are valid from that edge.
- bist_busy is high from edge k until edge k+N+2.
- RST asserted mid-run aborts immediately to reset values. No partial signature is retained.
- Counter wrap is impossible: N_PATTERNS ≤ 65535.

## Test plan
- Reset: assert RST mid-cycle → all outputs 0 asynchronously, state IDLE, bist_busy = 0.
- Functional, NUM_CH=1, func_in successive values → func_out two edges later:
  - 5'b11111 → 2'b01
  - 5'b00000 → 2'b00
  - 5'b00100 → 2'b10
- Multi-channel, NUM_CH=6: each channel driven with a distinct pattern → every 2-bit lane matches the per-channel formula; no cross-channel leakage.
- Minimal BIST, NUM_CH=1, N_PATTERNS=1, SEED=1, GOLDEN_SIG=16'h0000:
  - start → pattern 5'b00001, response 0;
  - bist_done at edge k+3, signature 16'h0000, bist_pass = 1.
  - Same run with GOLDEN_SIG=16'h0001 → bist_pass = 0.
- Full BIST, NUM_CH=6, N_PATTERNS=32: signature equals the reference model. A second start pulsed during RUN is ignored. A restart from DONE reproduces the identical signature.
- Reset mid-run, RST pulsed at pattern 10: all state returns to reset values. A subsequent start yields the same signature as an uninterrupted run.
